// File: rtl/root_module_fanin_collector_if.sv
// Handshake bundle between the fan-in collector and its surroundings.
//   child_valid/child_data/child_ready : NUM_CHILD child channels, child i
//                                        data at [i*DATA_W +: DATA_W]
//   out_valid/out_ready/out_data/out_idx : single tagged output channel
// The master modport is the collector side; slave is the environment side
// (children plus parent).
interface root_module_fanin_collector_if #(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 3
);
  logic [NUM_CHILD-1:0]        child_valid;
  logic [NUM_CHILD*DATA_W-1:0] child_data;
  logic [NUM_CHILD-1:0]        child_ready;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_W-1:0]           out_data;
  logic [IDX_W-1:0]            out_idx;

  modport master (
    input  child_valid, child_data, out_ready,
    output child_ready, out_valid, out_data, out_idx
  );

  modport slave (
    output child_valid, child_data, out_ready,
    input  child_ready, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/root_module_fanin_collector.sv
// Fan-in collector: return path of a root module's child instances.
// Round-robin arbitration over NUM_CHILD valid/ready child channels, one
// registered output stage tagged with the originating child index, and a
// saturating count of words handed to the parent.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         arbitration enable; low blocks new grants in the same cycle
//   bus        collector side (master) of the handshake bundle
//   fwd_count  words accepted by the parent, saturating at 2^CNT_W-1
//   idle       state is IDLE and the output stage is empty
module root_module_fanin_collector #(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 3,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  root_module_fanin_collector_if.master bus,
  output logic [CNT_W-1:0]              fwd_count,
  output logic                          idle
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]    out_idx_q, out_idx_d;
  logic [CNT_W-1:0]    fwd_count_q, fwd_count_d;
  logic                idle_q, idle_d;

  logic                load;
  logic                any_valid;
  logic                grant;
  logic                accept;
  logic [IDX_W-1:0]    gnt_idx;
  logic [IDX_W:0]      cand;
  logic [DATA_W-1:0]   gnt_data;
  logic [NUM_CHILD-1:0] child_ready_c;

  // Only a RUN-state cycle with en high may load, and only if the output
  // stage is empty or being emptied this very cycle (no-bubble replace).
  assign load   = (state_q == ST_RUN) && en && (!out_valid_q || bus.out_ready);
  assign accept = out_valid_q && bus.out_ready;
  // rst_n gates the grant so children never see a ready during reset.
  assign grant  = load && any_valid && rst_n;

  // Round-robin search starting at rr_ptr, wrapping NUM_CHILD-1 -> 0.
  always_comb begin
    any_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CHILD; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_CHILD)) cand = cand - (IDX_W+1)'(NUM_CHILD);
      if (!any_valid && bus.child_valid[cand[IDX_W-1:0]]) begin
        any_valid = 1'b1;
        gnt_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Constant-index mux keeps child_data off every combinational output.
  always_comb begin
    gnt_data      = '0;
    child_ready_c = '0;
    for (int i = 0; i < NUM_CHILD; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        gnt_data         = bus.child_data[i*DATA_W +: DATA_W];
        child_ready_c[i] = grant;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = out_valid_q ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: begin
        if (en) state_d = ST_RUN;
        // An empty stage also leaves DRAIN, so a word accepted on the
        // RUN->DRAIN cycle cannot strand the FSM.
        else if (!out_valid_q || bus.out_ready) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    fwd_count_d = fwd_count_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_idx_d   = gnt_idx;
      rr_ptr_d    = (gnt_idx == IDX_W'(NUM_CHILD-1)) ? '0 : gnt_idx + IDX_W'(1);
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
    if (accept && (fwd_count_q != {CNT_W{1'b1}})) fwd_count_d = fwd_count_q + CNT_W'(1);
    idle_d = (state_d == ST_IDLE) && !out_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      fwd_count_q <= '0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      fwd_count_q <= fwd_count_d;
      idle_q      <= idle_d;
    end
  end

  assign bus.child_ready = child_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_idx     = out_idx_q;
  assign fwd_count       = fwd_count_q;
  assign idle            = idle_q;

endmodule

// File: doc/root_module_fanin_collector.md
# root_module_fanin_collector

Fan-in collector for the generated root-module hierarchy. Where a root module fans out to five child instances, this block is the return path: it gathers result words from the NUM_CHILD children over valid/ready channels. It arbitrates between them round-robin and forwards one tagged word per cycle to the parent through a single registered output stage. It also keeps a saturating count of words forwarded.

## Interface

Parameters:
- NUM_CHILD, 5, number of child channels (2..8)
- DATA_W, 16, child data width
- IDX_W, 3, width of child index tag; must satisfy 2^IDX_W >= NUM_CHILD
- CNT_W, 16, width of forwarded-word counter

Ports (reset is synchronous, active-low; one clock domain):
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- en  in  1  arbitration enable; low stops new grants
- child_valid  in  NUM_CHILD  per-child word available
- child_data  in  NUM_CHILD*DATA_W  child i occupies bits [i*DATA_W +: DATA_W]
- child_ready  out  NUM_CHILD  per-child accept, one-hot or zero
- out_valid  out  1  output word held
- out_ready  in  1  parent accepts output word
- out_data  out  DATA_W  forwarded word
- out_idx  out  IDX_W  index of originating child
- fwd_count  out  CNT_W  words forwarded to parent, saturating
- idle  out  1  state is IDLE and output stage empty

## Operation

- **State machine** with three states:
  - IDLE: en low, output empty.
  - RUN: en high.
  - DRAIN: en low, output stage still full.
- **State transitions:**
  - IDLE→RUN when en=1.
  - RUN→DRAIN when en=0 and out_valid=1.
  - RUN→IDLE when en=0 and out_valid=0.
  - DRAIN→IDLE when the held word is accepted (out_valid & out_ready).
  - DRAIN→RUN when en=1.
- **Load condition:** load = (state==RUN or next-cycle-RUN is not used; only current state RUN) & en & (!out_valid | out_ready).
- **Arbitration:** combinational, searching from rr_ptr upward with wrap at NUM_CHILD-1→0. The first child with child_valid=1 is the grant g.
  - child_ready[g] = load; all other bits are 0.
  - child_ready is never asserted outside RUN or when en=0.
- **On grant** (load & any valid):
  - out_data <= child_data[g]; out_idx <= g; out_valid <= 1.
  - rr_ptr <= (g==NUM_CHILD-1) ? 0 : g+1.
- **Output drain:**
  - On out_valid & out_ready with no new grant, out_valid <= 0.
  - Accept and grant in the same cycle replace the word with no bubble.
- **Data stability:** out_data and out_idx hold stable while out_valid=1 and out_ready=0.
- **Counter:** fwd_count increments by 1 on each out_valid & out_ready and saturates at 2^CNT_W-1 (no wrap).
- **No-request case:** rr_ptr is unchanged when no child is valid.
- **Reset values:** state=IDLE, rr_ptr=0, out_valid=0, out_data=0, out_idx=0, fwd_count=0, child_ready=0, idle=1.
- **Reset mid-transfer:** a held word is discarded. Children see child_ready=0 in the reset cycle, so no word is lost on their side.

## Timing

- Child→output latency is 1 cycle: the word is accepted at edge N and appears on out_data after edge N.
- Sustained throughput is 1 word/cycle when out_ready=1 and any child is valid.
- Fairness: with all NUM_CHILD valid continuously, each child is granted exactly once every NUM_CHILD cycles.
- child_ready depends combinationally on child_valid, en, out_valid, out_ready and state. No combinational path exists from child_data to any output other than through the registers.
- Backpressure: with out_ready=0 and out_valid=1, all child_ready stay 0.
- An en deassertion takes effect on the same cycle: no grant occurs in a cycle where en=0.

## Test plan

- **Reset:** hold rst_n=0 for 3 cycles with all child_valid=1.
  - Expect child_ready=0, out_valid=0, fwd_count=0, idle=1.
  - After release with en=1, the first out_idx is 0.
- **Round-robin:** en=1, out_ready=1, all 5 children valid with data 0x1000+i.
  - out_idx sequence is 0,1,2,3,4,0,1 on consecutive cycles, with data matching.
  - fwd_count reaches 7.
- **Wrap/skip:** only children 1 and 4 valid, after a prior grant to 4.
  - Grant order is 1,4,1,4; rr_ptr wraps 4→0.
- **Backpressure:** out_ready=0 for 4 cycles while holding word 0xBEEF from child 2.
  - out_data stays 0xBEEF and child_ready stays 0.
  - When out_ready rises, the next child (3) loads in the same cycle with no bubble.
- **Enable/drain:** drop en while out_valid=1 and out_ready=0.
  - State goes to DRAIN with no grants.
  - After out_ready pulses once: out_valid=0, idle=1, fwd_count+1.
- **Saturation:** build with CNT_W=4 and forward 20 words.
  - fwd_count stops at 15.
